// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB-CDC TX arbiter: FSM state encoding, counter width, saturating increment.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package usb_tx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam int CNT_W = 8;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/usb_tx_arbiter_rr_pick.sv
// Round-robin one-hot picker: first requester at or after ptr, wrapping modulo N_SRC.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to use the pick.
// Ports: req = request vector, ptr = starting index, gnt = one-hot pick, any = at least one request.
module rr_pick #(
  parameter int N_SRC = 2,
  localparam int PW = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_SRC-1:0] gnt,
  output logic             any
);

  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N_SRC; k++) begin
      // ptr < N_SRC and k < N_SRC, so one conditional subtract is enough to wrap.
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N_SRC)) sum = sum - (PW+1)'(N_SRC);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/usb_tx_arbiter.sv
// Round-robin arbiter sharing one USB-CDC TX byte stream among N_SRC sources, grant held per packet.
// Latency: request in IDLE -> grant at edge 1, first beat accepted that cycle, m_val high after edge 2.
// Backpressure: s_rdy of the owner follows (~m_val | m_rdy); one registered output stage, full rate.
// Ports: clk/rst_n; s_data/s_val/s_last/s_rdy per source; m_data/m_val/m_rdy to MUACM; grant, busy status.
module usb_tx_arbiter
  import usb_tx_pkg::*;
#(
  parameter int N_SRC    = 2,
  parameter int DW       = 8,
  parameter int HOLD_MAX = 64,
  parameter int IDLE_TO  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_SRC*DW-1:0] s_data,
  input  logic [N_SRC-1:0]    s_val,
  input  logic [N_SRC-1:0]    s_last,
  output logic [N_SRC-1:0]    s_rdy,
  output logic [DW-1:0]       m_data,
  output logic                m_val,
  input  logic                m_rdy,
  output logic [N_SRC-1:0]    grant,
  output logic                busy
);

  localparam int PW = $clog2(N_SRC);

  state_e           state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    owner;
  logic [PW-1:0]    next_ptr;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] beat_nxt;
  logic [CNT_W-1:0] idle_nxt;
  logic [N_SRC-1:0] pick;
  logic             pick_any;
  logic             out_free;
  logic             accept;
  logic             g_val;
  logic             g_last;
  logic             release_now;
  logic [DW-1:0]    g_data;

  rr_pick #(.N_SRC(N_SRC)) u_pick (
    .req (s_val),
    .ptr (rr_ptr),
    .gnt (pick),
    .any (pick_any)
  );

  // Output slot is free when empty or draining this cycle; the only comb path from m_rdy.
  assign out_free = ~m_val | m_rdy;
  assign s_rdy    = (state == ST_GRANT && out_free) ? grant : '0;
  assign accept   = |(s_val & s_rdy);
  assign g_val    = |(s_val & grant);
  assign g_last   = |(s_last & grant);

  // Owner's data and index; everything belonging to other sources is masked off.
  always_comb begin
    g_data = '0;
    owner  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant[i]) begin
        g_data = g_data | s_data[i*DW +: DW];
        owner  = PW'(i);
      end
    end
  end

  assign next_ptr = (owner == PW'(N_SRC-1)) ? '0 : owner + PW'(1);
  assign beat_nxt = sat_inc(beat_cnt);
  assign idle_nxt = sat_inc(idle_cnt);

  // All release causes fold into one flag, so coincident causes give a single release.
  assign release_now = accept ? (g_last || beat_nxt >= CNT_W'(HOLD_MAX))
                              : (!g_val && idle_nxt >= CNT_W'(IDLE_TO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant    <= pick;
            state    <= ST_GRANT;
            beat_cnt <= '0;
            idle_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (accept) begin
            beat_cnt <= beat_nxt;
            idle_cnt <= '0;
          end else if (!g_val) begin
            idle_cnt <= idle_nxt;
          end
          if (release_now) begin
            grant  <= '0;
            state  <= ST_IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output stage drains on its own, so a new grant may start while the previous byte is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_val  <= 1'b0;
      m_data <= '0;
    end else if (accept) begin
      m_val  <= 1'b1;
      m_data <= g_data;
    end else if (m_rdy) begin
      m_val  <= 1'b0;
    end
  end

  assign busy = (state == ST_GRANT) | m_val;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Directed bench for usb_tx_arbiter (N_SRC=2, HOLD_MAX=4, IDLE_TO=5).
// Inputs change on the falling edge; outputs are sampled on the falling edge or shortly after it.
// Source 1 data always has bit 7 set so output beats can be attributed to their source.
module tb_usb_tx_arbiter;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] s_data = '0;
  logic [1:0]  s_val = '0;
  logic [1:0]  s_last = '0;
  logic [1:0]  s_rdy;
  logic [7:0]  m_data;
  logic        m_val;
  logic        m_rdy = 1'b1;
  logic [1:0]  grant;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] sq[2][$];   // per-source {last, data} still to be sent
  logic [1:0] src_en = '0;
  bq_t        obs0, obs1, obs_all;
  logic [1:0] glog[$];
  logic [1:0] gprev = '0;

  usb_tx_arbiter #(.N_SRC(2), .DW(8), .HOLD_MAX(4), .IDLE_TO(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_data (s_data),
    .s_val  (s_val),
    .s_last (s_last),
    .s_rdy  (s_rdy),
    .m_data (m_data),
    .m_val  (m_val),
    .m_rdy  (m_rdy),
    .grant  (grant),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_q(input string tag, input bq_t got, input bq_t exp);
    check({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s[%0d]", tag, i), (i < got.size()) ? {24'h0, got[i]} : 32'hFFFF_FFFF, {24'h0, exp[i]});
  endtask

  // Present queue heads of enabled sources.
  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if (src_en[i] && sq[i].size() > 0) begin
        s_val[i]          = 1'b1;
        s_data[i*8 +: 8]  = sq[i][0][7:0];
        s_last[i]         = sq[i][0][8];
      end else begin
        s_val[i]          = 1'b0;
        s_last[i]         = 1'b0;
        s_data[i*8 +: 8]  = 8'h00;
      end
    end
  endtask

  // One clock: log handshakes that will occur at the next rising edge, then advance to the falling edge.
  task automatic cyc();
    logic [1:0] fire;
    #1;
    fire = s_val & s_rdy;
    if (m_val && m_rdy) begin
      if (m_data[7]) obs1.push_back(m_data);
      else           obs0.push_back(m_data);
      obs_all.push_back(m_data);
    end
    if (grant != 2'b00 && gprev == 2'b00) glog.push_back(grant);
    gprev = grant;
    @(posedge clk);
    for (int i = 0; i < 2; i++)
      if (fire[i] && sq[i].size() > 0) sq[i].delete(0);
    @(negedge clk);
  endtask

  task automatic run(input int budget, input string tag);
    int   n;
    logic done;
    n    = 0;
    done = 1'b0;
    while (n < budget && !done) begin
      drive();
      cyc();
      n++;
      done = (sq[0].size() == 0 && sq[1].size() == 0 && grant == 2'b00 && !m_val);
    end
    check({tag, "_done"}, {31'h0, done}, 32'h1);
  endtask

  task automatic clear_logs();
    obs0.delete();
    obs1.delete();
    obs_all.delete();
    glog.delete();
  endtask

  initial begin
    bq_t        e0, e1, ea;
    logic [1:0] eg[$];

    // 1. Reset with all sources requesting.
    s_val  = 2'b11;
    s_data = 16'hBEEF;
    m_rdy  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_m_val", {31'h0, m_val}, 32'h0);
    check("rst_m_data", {24'h0, m_data}, 32'h0);
    check("rst_grant", {30'h0, grant}, 32'h0);
    check("rst_s_rdy", {30'h0, s_rdy}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_first_grant", {30'h0, grant}, 32'h1);
    rst_n  = 1'b0;
    s_val  = 2'b00;
    s_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 2. Single source, three-byte packet.
    clear_logs();
    src_en = 2'b01;
    sq[0].push_back(9'h041);
    sq[0].push_back(9'h042);
    sq[0].push_back(9'h143);
    drive(); cyc();
    check("t2_grant", {30'h0, grant}, 32'h1);
    check("t2_busy", {31'h0, busy}, 32'h1);
    drive(); cyc();
    check("t2_val0", {31'h0, m_val}, 32'h1);
    check("t2_dat0", {24'h0, m_data}, 32'h41);
    drive(); cyc();
    check("t2_dat1", {24'h0, m_data}, 32'h42);
    drive(); cyc();
    check("t2_dat2", {24'h0, m_data}, 32'h43);
    check("t2_release", {30'h0, grant}, 32'h0);
    drive(); cyc();
    check("t2_drained", {31'h0, m_val}, 32'h0);

    // 3. Contention: three 4-beat packets per source; pointer now favours source 1.
    clear_logs();
    e0.delete(); e1.delete();
    for (int i = 0; i < 12; i++) begin
      sq[0].push_back({(i % 4 == 3) ? 1'b1 : 1'b0, 8'(i)});
      sq[1].push_back({(i % 4 == 3) ? 1'b1 : 1'b0, 8'(8'h80 + i)});
      e0.push_back(8'(i));
      e1.push_back(8'(8'h80 + i));
    end
    src_en = 2'b11;
    run(200, "t3");
    check_q("t3_src0", obs0, e0);
    check_q("t3_src1", obs1, e1);
    eg = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    check("t3_ngrants", glog.size(), eg.size());
    for (int i = 0; i < eg.size(); i++)
      check($sformatf("t3_grant[%0d]", i), (i < glog.size()) ? {30'h0, glog[i]} : 32'hF, {30'h0, eg[i]});

    // 4. Hold limit: source 0 streams 10 beats without last, source 1 joins with a 2-beat packet.
    clear_logs();
    for (int i = 0; i < 10; i++) sq[0].push_back({1'b0, 8'(8'h10 + i)});
    sq[1].push_back(9'h090);
    sq[1].push_back(9'h191);
    src_en = 2'b01;
    drive(); cyc();
    src_en = 2'b11;
    run(200, "t4");
    ea = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h90, 8'h91, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
    check_q("t4_order", obs_all, ea);
    eg = '{2'b01, 2'b10, 2'b01, 2'b01};
    check("t4_ngrants", glog.size(), eg.size());
    for (int i = 0; i < eg.size(); i++)
      check($sformatf("t4_grant[%0d]", i), (i < glog.size()) ? {30'h0, glog[i]} : 32'hF, {30'h0, eg[i]});

    // 5. Backpressure: stall output for 5 cycles after the first beat.
    clear_logs();
    src_en = 2'b10;
    for (int i = 0; i < 4; i++) sq[1].push_back({(i == 3) ? 1'b1 : 1'b0, 8'(8'hA0 + i)});
    drive(); cyc();
    drive(); cyc();
    for (int k = 0; k < 5; k++) begin
      m_rdy = 1'b0;
      drive();
      #1;
      check($sformatf("t5_s_rdy%0d", k), {30'h0, s_rdy}, 32'h0);
      check($sformatf("t5_val%0d", k), {31'h0, m_val}, 32'h1);
      check($sformatf("t5_dat%0d", k), {24'h0, m_data}, 32'hA0);
      cyc();
    end
    m_rdy = 1'b1;
    run(100, "t5");
    e1 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    check_q("t5_src1", obs1, e1);

    // 6. Idle timeout, then asynchronous reset with a byte held in the output register.
    src_en = 2'b00;
    s_val  = 2'b01;
    s_data = 16'h0055;
    s_last = 2'b00;
    cyc();
    check("t6_grant", {30'h0, grant}, 32'h1);
    s_val = 2'b00;
    repeat (4) cyc();
    check("t6_hold", {30'h0, grant}, 32'h1);
    cyc();
    check("t6_timeout", {30'h0, grant}, 32'h0);
    s_val  = 2'b01;
    s_data = 16'h0066;
    cyc();
    cyc();
    s_val = 2'b00;
    m_rdy = 1'b0;
    check("t6_pending_val", {31'h0, m_val}, 32'h1);
    check("t6_pending_dat", {24'h0, m_data}, 32'h66);
    #2 rst_n = 1'b0;
    #1;
    check("t6_arst_m_val", {31'h0, m_val}, 32'h0);
    check("t6_arst_grant", {30'h0, grant}, 32'h0);
    check("t6_arst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_rdy = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
